// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings for the multiply/divide unit
package mips_pkg;

    localparam int MD_DATA_W = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - unsigned shift-add multiplier / restoring divider datapath
module muldiv_core #(
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  kind_i,
    input  logic [DATA_W-1:0]     a_mag_i,
    input  logic [DATA_W-1:0]     b_mag_i,
    output logic [2*DATA_W-1:0]   prod_mag_o,
    output logic [DATA_W-1:0]     quo_mag_o,
    output logic [DATA_W-1:0]     rem_mag_o
);

    // acc holds the running high half (mul) or partial remainder (div);
    // shreg holds the multiplier bits / dividend bits being shifted out and
    // the product low half / quotient bits being shifted in.
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic              kind_q, kind_d;

    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              ge;

    always_comb begin
        acc_d   = acc_q;
        shreg_d = shreg_q;
        opnd_d  = opnd_q;
        kind_d  = kind_q;
        addend  = shreg_q[0] ? opnd_q : '0;
        sum     = {1'b0, acc_q} + {1'b0, addend};
        shifted = {acc_q, shreg_q[DATA_W-1]};
        diff    = shifted - {1'b0, opnd_q};
        ge      = (shifted >= {1'b0, opnd_q});
        if (load_i) begin
            acc_d  = '0;
            kind_d = kind_i;
            if (kind_i) begin
                opnd_d  = b_mag_i;
                shreg_d = a_mag_i;
            end else begin
                opnd_d  = a_mag_i;
                shreg_d = b_mag_i;
            end
        end else if (step_i) begin
            if (!kind_q) begin
                acc_d   = sum[DATA_W:1];
                shreg_d = {sum[0], shreg_q[DATA_W-1:1]};
            end else if (ge) begin
                acc_d   = diff[DATA_W-1:0];
                shreg_d = {shreg_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_d   = shifted[DATA_W-1:0];
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q   <= '0;
            shreg_q <= '0;
            opnd_q  <= '0;
            kind_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            opnd_q  <= opnd_d;
            kind_q  <= kind_d;
        end
    end

    assign prod_mag_o = {acc_q, shreg_q};
    assign quo_mag_o  = shreg_q;
    assign rem_mag_o  = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - MIPS mult/div FSM with HI/LO registers and EX-stage stall
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_E,
    input  logic [1:0]            op_E,
    input  logic [DATA_W-1:0]     src_a_E,
    input  logic [DATA_W-1:0]     src_b_E,
    input  logic                  hilo_rd_E,
    input  logic                  mt_en_E,
    input  logic                  mt_sel_E,
    input  logic [DATA_W-1:0]     mt_data_E,
    output logic                  stall,
    output logic                  busy,
    output logic [2*DATA_W-1:0]   product,
    output logic [DATA_W-1:0]     quotient,
    output logic [DATA_W-1:0]     remainder,
    output logic                  mult_ready,
    output logic                  div_ready,
    output logic                  hi_lo_en,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    md_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic                  div0_q, div0_d;
    logic                  is_div_q, is_div_d;
    logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [2*DATA_W-1:0]   product_q, product_d;
    logic [DATA_W-1:0]     quotient_q, quotient_d;
    logic [DATA_W-1:0]     remainder_q, remainder_d;
    logic                  mult_ready_q, mult_ready_d;
    logic                  div_ready_q, div_ready_d;
    logic                  hi_lo_en_q, hi_lo_en_d;

    logic                  core_load, core_step;
    logic                  op_signed;
    logic [DATA_W-1:0]     a_mag, b_mag;
    logic [2*DATA_W-1:0]   prod_mag, prod_fix;
    logic [DATA_W-1:0]     quo_mag, rem_mag, quo_fix, rem_fix;

    assign op_signed = ~op_E[0];
    assign a_mag     = (op_signed && src_a_E[DATA_W-1]) ? -src_a_E : src_a_E;
    assign b_mag     = (op_signed && src_b_E[DATA_W-1]) ? -src_b_E : src_b_E;

    assign busy  = (state_q != IDLE);
    assign stall = busy && (start_E || hilo_rd_E || mt_en_E);

    muldiv_core #(.DATA_W(DATA_W)) u_core (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (core_load),
        .step_i     (core_step),
        .kind_i     (op_E[1]),
        .a_mag_i    (a_mag),
        .b_mag_i    (b_mag),
        .prod_mag_o (prod_mag),
        .quo_mag_o  (quo_mag),
        .rem_mag_o  (rem_mag)
    );

    // Divide by zero keeps the all-ones quotient regardless of sign; the
    // remainder naturally reconstructs the dividend from |a| and a's sign.
    assign prod_fix = neg_q ? -prod_mag : prod_mag;
    assign quo_fix  = div0_q ? '1 : (neg_q ? -quo_mag : quo_mag);
    assign rem_fix  = rem_neg_q ? -rem_mag : rem_mag;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        rem_neg_d    = rem_neg_q;
        div0_d       = div0_q;
        is_div_d     = is_div_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        product_d    = product_q;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        mult_ready_d = 1'b0;
        div_ready_d  = 1'b0;
        hi_lo_en_d   = 1'b0;
        core_load    = 1'b0;
        core_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_E && !stall) begin
                    core_load = 1'b1;
                    cnt_d     = '0;
                    is_div_d  = op_E[1];
                    state_d   = op_E[1] ? DIV : MUL;
                    neg_d     = op_signed && (src_a_E[DATA_W-1] ^ src_b_E[DATA_W-1]);
                    rem_neg_d = op_signed && src_a_E[DATA_W-1];
                    div0_d    = (src_b_E == '0);
                end else if (mt_en_E) begin
                    if (mt_sel_E) hi_d = mt_data_E;
                    else          lo_d = mt_data_E;
                end
            end
            MUL, DIV: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = DONE;
            end
            DONE: begin
                state_d    = IDLE;
                hi_lo_en_d = 1'b1;
                if (is_div_q) begin
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                    hi_d        = rem_fix;
                    lo_d        = quo_fix;
                    div_ready_d = 1'b1;
                end else begin
                    product_d    = prod_fix;
                    hi_d         = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d         = prod_fix[DATA_W-1:0];
                    mult_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            rem_neg_q    <= 1'b0;
            div0_q       <= 1'b0;
            is_div_q     <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            product_q    <= '0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            mult_ready_q <= 1'b0;
            div_ready_q  <= 1'b0;
            hi_lo_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            neg_q        <= neg_d;
            rem_neg_q    <= rem_neg_d;
            div0_q       <= div0_d;
            is_div_q     <= is_div_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            product_q    <= product_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            mult_ready_q <= mult_ready_d;
            div_ready_q  <= div_ready_d;
            hi_lo_en_q   <= hi_lo_en_d;
        end
    end

    assign hi         = hi_q;
    assign lo         = lo_q;
    assign product    = product_q;
    assign quotient   = quotient_q;
    assign remainder  = remainder_q;
    assign mult_ready = mult_ready_q;
    assign div_ready  = div_ready_q;
    assign hi_lo_en   = hi_lo_en_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import mips_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start_E = 1'b0;
    logic [1:0]  op_E = 2'b00;
    logic [31:0] src_a_E = '0, src_b_E = '0;
    logic        hilo_rd_E = 1'b0, mt_en_E = 1'b0, mt_sel_E = 1'b0;
    logic [31:0] mt_data_E = '0;
    logic        stall, busy, mult_ready, div_ready, hi_lo_en;
    logic [63:0] product;
    logic [31:0] quotient, remainder, hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST), .start_E(start_E), .op_E(op_E),
        .src_a_E(src_a_E), .src_b_E(src_b_E), .hilo_rd_E(hilo_rd_E),
        .mt_en_E(mt_en_E), .mt_sel_E(mt_sel_E), .mt_data_E(mt_data_E),
        .stall(stall), .busy(busy), .product(product), .quotient(quotient),
        .remainder(remainder), .mult_ready(mult_ready), .div_ready(div_ready),
        .hi_lo_en(hi_lo_en), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: MIPS arithmetic written directly with SV integer operators.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ehi, output logic [31:0] elo);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        ehi = '0;
        elo = '0;
        case (op)
            MD_MULT: begin
                sp = sa * sb;
                ehi = sp[63:32];
                elo = sp[31:0];
            end
            MD_MULTU: begin
                up = ua * ub;
                ehi = up[63:32];
                elo = up[31:0];
            end
            default: begin
                if (b == 0) begin
                    elo = 32'hFFFF_FFFF;
                    ehi = a;
                end else if (op == MD_DIVU) begin
                    elo = a / b;
                    ehi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    elo = 32'h8000_0000;
                    ehi = 32'h0;
                end else begin
                    elo = ia / ib;
                    ehi = ia % ib;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        int   window_bad;
        logic is_mul;
        window_bad = 0;
        is_mul = ~op[1];
        @(negedge CLK);
        start_E = 1'b1; op_E = op; src_a_E = a; src_b_E = b;
        @(posedge CLK);
        #1 start_E = 1'b0;
        for (int i = 0; i < 33; i++) begin
            @(negedge CLK);
            if (busy !== 1'b1 || mult_ready !== 1'b0 || div_ready !== 1'b0 || hi_lo_en !== 1'b0)
                window_bad++;
        end
        chk({tag, " busy_window"}, 64'(window_bad), 64'd0);
        @(negedge CLK);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
        chk({tag, " mult_ready"}, 64'(mult_ready), 64'(is_mul));
        chk({tag, " div_ready"}, 64'(div_ready), 64'(!is_mul));
        chk({tag, " hi_lo_en"}, 64'(hi_lo_en), 64'd1);
        chk({tag, " hi"}, 64'(hi), 64'(ehi));
        chk({tag, " lo"}, 64'(lo), 64'(elo));
        if (is_mul) begin
            chk({tag, " product"}, product, {ehi, elo});
        end else begin
            chk({tag, " quotient"}, 64'(quotient), 64'(elo));
            chk({tag, " remainder"}, 64'(remainder), 64'(ehi));
        end
        @(negedge CLK);
        chk({tag, " pulses_clear"}, 64'({mult_ready, div_ready, hi_lo_en}), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] mhi, mlo, ra, rb;
        logic [1:0]  rop;
        int          stall_bad, quiet_bad;

        vecs[0] = '{MD_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'd100,        32'd7,         32'd2,         32'd14};
        vecs[4] = '{MD_DIVU,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[5] = '{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[6] = '{MD_DIV,   32'hFFFF_FFF7,  32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};

        #12;
        chk("reset flags", 64'({busy, stall, mult_ready, div_ready, hi_lo_en}), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset product", product, 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        @(negedge CLK);
        mt_en_E = 1'b1; mt_sel_E = 1'b1; mt_data_E = 32'h0000_1234;
        @(negedge CLK);
        mt_sel_E = 1'b0; mt_data_E = 32'h0000_5678;
        @(negedge CLK);
        mt_en_E = 1'b0;
        chk("mthi idle", 64'(hi), 64'h1234);
        chk("mtlo idle", 64'(lo), 64'h5678);

        for (int k = 0; k < 7; k++)
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].ehi, vecs[k].elo, $sformatf("vec%0d", k));

        // Dependent MFLO arrives in the 5th cycle of a MULT.
        stall_bad = 0;
        @(negedge CLK);
        start_E = 1'b1; op_E = MD_MULT; src_a_E = 32'd5; src_b_E = 32'hFFFF_FFFA;
        @(posedge CLK);
        #1 start_E = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge CLK);
            hilo_rd_E = (i >= 4);
            #1;
            if (stall !== ((i >= 4 && i <= 32) ? 1'b1 : 1'b0)) stall_bad++;
            if (i == 33) chk("mflo after stall", 64'(lo), 64'hFFFF_FFE2);
        end
        hilo_rd_E = 1'b0;
        chk("stall window", 64'(stall_bad), 64'd0);

        for (int k = 0; k < 20; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            model(rop, ra, rb, mhi, mlo);
            run_op(rop, ra, rb, mhi, mlo, $sformatf("rnd%0d op%0d", k, rop));
        end

        // Asynchronous reset in the middle of a divide.
        @(negedge CLK);
        start_E = 1'b1; op_E = MD_DIVU; src_a_E = 32'd1000; src_b_E = 32'd3;
        @(posedge CLK);
        #1 start_E = 1'b0;
        repeat (9) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("midop reset flags", 64'({busy, stall, mult_ready, div_ready, hi_lo_en}), 64'd0);
        chk("midop reset hi", 64'(hi), 64'd0);
        chk("midop reset lo", 64'(lo), 64'd0);
        chk("midop reset product", product, 64'd0);
        chk("midop reset quo_rem", {quotient, remainder}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        quiet_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if ({busy, mult_ready, div_ready, hi_lo_en} !== 4'b0) quiet_bad++;
        end
        chk("no result after reset", 64'(quiet_bad), 64'd0);
        run_op(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "post reset multu");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
